// File: rtl/div_job_sequencer_pkg.sv
// Shared divider definitions: FSM encoding, default widths
// and result flag bit positions.
package div_job_sequencer_pkg;

    localparam int DVD_W_DEF = 10;
    localparam int DVS_W_DEF = 5;

    // One-hot so a single-bit upset lands in an illegal code.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_LAUNCH = 4'b0010,
        ST_WAIT   = 4'b0100,
        ST_RESP   = 4'b1000
    } state_e;

    localparam int FLG_OV  = 0;
    localparam int FLG_DBZ = 1;
    localparam int FLG_TMO = 2;
    localparam int FLG_W   = 3;

    function automatic logic [FLG_W-1:0] err_flags(
        input logic dbz,
        input logic ov
    );
        logic [FLG_W-1:0] f;
        f          = '0;
        f[FLG_DBZ] = dbz;
        f[FLG_OV]  = ov & ~dbz;
        return f;
    endfunction

endpackage

// File: rtl/div_timeout_counter.sv
// WAIT-state watchdog: counts enabled cycles from zero and
// flags the last allowed cycle.
module div_timeout_counter #(
    parameter int TMO_CYC = 15
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CW'(TMO_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/div_job_sequencer.sv
// Job sequencer in front of a multi-cycle divider: screens
// operands, launches the divider, guards it with a watchdog.
module div_job_sequencer
    import div_job_sequencer_pkg::*;
#(
    parameter int DVD_W   = DVD_W_DEF,
    parameter int DVS_W   = DVS_W_DEF,
    parameter int TMO_CYC = 15
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] in_dividend,
    input  logic [DVS_W-1:0] in_divisor,
    output logic             div_start,
    output logic [DVD_W-1:0] div_dividend,
    output logic [DVS_W-1:0] div_divisor,
    input  logic             div_done,
    input  logic [DVS_W-1:0] div_quo,
    input  logic [DVS_W-1:0] div_rem,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVS_W-1:0] out_quo,
    output logic [DVS_W-1:0] out_rem,
    output logic             out_ov,
    output logic             out_dbz,
    output logic             out_tmo
);

    state_e             state_q, state_d;
    logic [DVD_W-1:0]   dvd_q, dvd_d;
    logic [DVS_W-1:0]   dvs_q, dvs_d;
    logic [DVS_W-1:0]   quo_q, quo_d;
    logic [DVS_W-1:0]   rem_q, rem_d;
    logic [FLG_W-1:0]   flg_q, flg_d;
    logic [FLG_W-1:0]   new_flg;
    logic [DVS_W-1:0]   dvd_hi;
    logic               tmo_hit;

    // Quotient overflows DVS_W bits whenever the upper half
    // of the dividend is not below the divisor.
    assign dvd_hi  = in_dividend[DVD_W-1:DVS_W];
    assign new_flg = err_flags(in_divisor == '0, dvd_hi >= in_divisor);

    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_RESP);
    assign div_start    = (state_q == ST_LAUNCH);
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign out_quo      = quo_q;
    assign out_rem      = rem_q;
    assign out_ov       = flg_q[FLG_OV];
    assign out_dbz      = flg_q[FLG_DBZ];
    assign out_tmo      = flg_q[FLG_TMO];

    div_timeout_counter #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr_i (state_q != ST_WAIT),
        .en_i  (state_q == ST_WAIT),
        .tc_o  (tmo_hit)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        flg_d   = flg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dvd_d   = in_dividend;
                    dvs_d   = in_divisor;
                    quo_d   = '0;
                    rem_d   = '0;
                    flg_d   = new_flg;
                    state_d = (|new_flg) ? ST_RESP : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done) begin
                    quo_d   = div_quo;
                    rem_d   = div_rem;
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    quo_d          = '0;
                    rem_d          = '0;
                    flg_d[FLG_TMO] = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    quo_d   = '0;
                    rem_d   = '0;
                    flg_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                quo_d   = '0;
                rem_d   = '0;
                flg_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            flg_q   <= flg_d;
        end
    end

endmodule

// File: tb/tb_div_job_sequencer.sv
// Randomized bench for div_job_sequencer with a behavioural
// divider and result model.
module tb_div_job_sequencer;

    localparam int DVD_W = 10;
    localparam int DVS_W = 5;
    localparam int TMO   = 15;

    logic             CLK;
    logic             RST_N;
    logic             in_valid;
    logic             in_ready;
    logic [DVD_W-1:0] in_dividend;
    logic [DVS_W-1:0] in_divisor;
    logic             div_start;
    logic [DVD_W-1:0] div_dividend;
    logic [DVS_W-1:0] div_divisor;
    logic             div_done;
    logic [DVS_W-1:0] div_quo;
    logic [DVS_W-1:0] div_rem;
    logic             out_valid;
    logic             out_ready;
    logic [DVS_W-1:0] out_quo;
    logic [DVS_W-1:0] out_rem;
    logic             out_ov;
    logic             out_dbz;
    logic             out_tmo;

    int vec_cnt = 0;
    int err_cnt = 0;

    int             lat_g;
    int             cd;
    int             starts;
    logic [DVS_W-1:0] ref_q;
    logic [DVS_W-1:0] ref_r;

    div_job_sequencer #(
        .DVD_W   (DVD_W),
        .DVS_W   (DVS_W),
        .TMO_CYC (TMO)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_done     (div_done),
        .div_quo      (div_quo),
        .div_rem      (div_rem),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quo      (out_quo),
        .out_rem      (out_rem),
        .out_ov       (out_ov),
        .out_dbz      (out_dbz),
        .out_tmo      (out_tmo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Divider model: done pulses lat_g cycles after the start cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
        div_done = 1'b0;
        div_quo  = DVS_W'($urandom);
        div_rem  = DVS_W'($urandom);
        if (div_start) begin
            starts++;
            cd = lat_g;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                div_done = 1'b1;
                div_quo  = ref_q;
                div_rem  = ref_r;
            end
        end
    endtask

    task automatic check_out(input string tag, input logic [DVS_W-1:0] q,
                             input logic [DVS_W-1:0] r, input logic ov,
                             input logic dbz, input logic tmo);
        check({tag, "_quo"}, out_quo, q);
        check({tag, "_rem"}, out_rem, r);
        check({tag, "_ov"},  out_ov,  ov);
        check({tag, "_dbz"}, out_dbz, dbz);
        check({tag, "_tmo"}, out_tmo, tmo);
    endtask

    task automatic run_job(input logic [DVD_W-1:0] dvd,
                           input logic [DVS_W-1:0] dvs,
                           input int lat, input int bp);
        logic             dbz, ov, tmo;
        logic [DVS_W-1:0] eq, er;
        int               exp_lat, t;
        dbz = (dvs == 0);
        ov  = !dbz && ((dvd >> DVS_W) >= DVD_W'(dvs));
        tmo = 1'b0;
        eq  = '0;
        er  = '0;
        ref_q = (dvs != 0) ? DVS_W'(dvd / dvs) : '0;
        ref_r = (dvs != 0) ? DVS_W'(dvd % dvs) : '0;
        if (dbz || ov) begin
            exp_lat = 1;
        end else if (lat >= 1 && lat <= TMO) begin
            exp_lat = 2 + lat;
            eq = ref_q;
            er = ref_r;
        end else begin
            exp_lat = 2 + TMO;
            tmo = 1'b1;
        end
        lat_g  = lat;
        starts = 0;
        cd     = 0;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        check("in_ready", in_ready, 1);
        in_valid    = 1'b1;
        in_dividend = dvd;
        in_divisor  = dvs;
        tick();
        in_valid    = 1'b0;
        in_dividend = DVD_W'($urandom);
        in_divisor  = DVS_W'($urandom);
        check("dvd_cap", div_dividend, dvd);
        check("dvs_cap", div_divisor, dvs);
        t = 1;
        while (!out_valid && t < exp_lat + 10) begin
            tick();
            t++;
        end
        check("latency", t, exp_lat);
        check("out_valid", out_valid, 1);
        check_out("res", eq, er, ov, dbz, tmo);
        for (int i = 0; i < bp; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check_out("hold", eq, er, ov, dbz, tmo);
        end
        check("starts", starts, (dbz || ov) ? 1'b0 : 1'b1);
        check("dvd_stable", div_dividend, dvd);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("released", out_valid, 0);
        check("ready_after", in_ready, 1);
        cd = 0;
    endtask

    initial begin
        RST_N       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        div_done    = 1'b0;
        div_quo     = '0;
        div_rem     = '0;
        out_ready   = 1'b0;
        lat_g  = 0;
        cd     = 0;
        starts = 0;
        ref_q  = '0;
        ref_r  = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_start", div_start, 0);
        check("rst_dvd", div_dividend, 0);
        check("rst_dvs", div_divisor, 0);
        check_out("rst", '0, '0, 1'b0, 1'b0, 1'b0);
        RST_N = 1'b1;
        tick();
        check("rst_ready", in_ready, 1);

        run_job(10'd100, 5'd7, 6, 0);
        run_job(10'd50, 5'd0, 6, 0);
        run_job(10'd600, 5'd10, 6, 0);
        run_job(10'd100, 5'd7, 3, 5);
        run_job(10'd100, 5'd7, TMO + 3, 6);
        run_job(10'd250, 5'd9, TMO, 0);
        run_job(10'd250, 5'd9, TMO + 1, 0);
        run_job(10'd0, 5'd1, 1, 1);
        run_job(10'd1023, 5'd31, 2, 0);
        run_job(10'd991, 5'd31, 2, 0);

        // Abort a job while the divider is busy.
        lat_g  = 10;
        ref_q  = 5'd14;
        ref_r  = 5'd2;
        in_valid    = 1'b1;
        in_dividend = 10'd100;
        in_divisor  = 5'd7;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        RST_N = 1'b0;
        #2;
        cd       = 0;
        div_done = 1'b0;
        check("mid_valid", out_valid, 0);
        check("mid_start", div_start, 0);
        check("mid_dvd", div_dividend, 0);
        check("mid_dvs", div_divisor, 0);
        check_out("mid", '0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        check("mid_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_noresp", out_valid, 0);
        end
        run_job(10'd100, 5'd7, 6, 0);

        for (int n = 0; n < 40; n++) begin
            logic [DVD_W-1:0] dvd;
            logic [DVS_W-1:0] dvs;
            if ($urandom_range(0, 3) == 0) begin
                dvd = DVD_W'($urandom);
                dvs = DVS_W'($urandom_range(0, 31));
            end else begin
                dvs = DVS_W'($urandom_range(1, 31));
                dvd = DVD_W'($urandom_range(0, int'(dvs) * 32 - 1));
            end
            run_job(dvd, dvs, $urandom_range(1, TMO + 3),
                    $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
